pwm_multi: RTL

Multi-channel hardware PWM generator. It is the parametrised successor to the single-channel PWM we currently run as a PIO program.
- NUM_CH channels share one period counter and one fractional clock divider.
- Each channel has its own duty cycle, polarity and enable bit.
- Duty and period writes are double-buffered and commit only at the period boundary, so updates never glitch.
- Configured through the same action/index/din strobe interface as pio; sits beside pio on the host bus.

---
 rtl/pwm_multi.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter and fractional divider, per-channel
// double-buffered duty, polarity and enable. Optional center mode: PWM_CENTER_EN.
// Ports: clk, reset (async, active-high), action/index/din command strobe,
// dout registered readback, pwm_out[NUM_CH], wrap pulse, running.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        action,
  input  logic [IDX_W-1:0]  index,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              wrap,
  output logic              running
);

  localparam logic [3:0] A_PERIOD = 4'd1;
  localparam logic [3:0] A_DUTY   = 4'd2;
  localparam logic [3:0] A_DIV    = 4'd3;
  localparam logic [3:0] A_EN     = 4'd4;
  localparam logic [3:0] A_POL    = 4'd5;
  localparam logic [3:0] A_READ   = 4'd6;
`ifdef PWM_CENTER_EN
  localparam logic [3:0] A_CMODE  = 4'd7;
`endif

  logic [CNT_W-1:0]  period_sh_q;
  logic [CNT_W-1:0]  period_act_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [15:0]       div_int_q;
  logic [7:0]        div_frac_q;
  logic [15:0]       div_cnt_q;
  logic [7:0]        acc_q;
  logic              ext_q;
  logic [NUM_CH-1:0] en_q, pol_q;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              wrap_q, wrap_d;
  logic [15:0]       wrap_cnt_q;
  logic [31:0]       dout_q;
  logic [15:0]       cnt16;
`ifdef PWM_CENTER_EN
  logic              cmode_q;
  logic              dir_q, dir_d;
`endif

  logic              run;
  logic              en_rise;
  logic              div_rst;
  logic              div_last;
  logic              carry;
  logic [7:0]        acc_sum;
  logic              tick;
  logic              at_top;
  logic              unused_din;

  assign unused_din = ^din;

  assign run     = en_q != '0;
  assign en_rise = (action == A_EN) && !run && (din[NUM_CH-1:0] != '0);
  // Divider is held idle while stopped so a fresh start is phase-aligned.
  assign div_rst = en_rise || (action == A_DIV) || !run;

  // div_int of 0 wraps to 0xFFFF here, i.e. a 65536-clk interval.
  assign div_last        = div_cnt_q == (div_int_q - 16'd1);
  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, div_frac_q};
  // A fractional carry delays the tick by one extra clk (ext_q).
  assign tick   = run && (ext_q || (div_last && !carry));
  assign at_top = cnt_q == period_act_q;

  generate
    if (CNT_W >= 16) begin : g_c16
      assign cnt16 = cnt_q[15:0];
    end else begin : g_c16z
      assign cnt16 = {{(16 - CNT_W){1'b0}}, cnt_q};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      acc_q     <= '0;
      ext_q     <= 1'b0;
    end else if (div_rst) begin
      div_cnt_q <= '0;
      acc_q     <= '0;
      ext_q     <= 1'b0;
    end else if (ext_q) begin
      div_cnt_q <= '0;
      ext_q     <= 1'b0;
    end else if (div_last) begin
      div_cnt_q <= '0;
      acc_q     <= acc_sum;
      ext_q     <= carry;
    end else begin
      div_cnt_q <= div_cnt_q + 16'd1;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
`ifdef PWM_CENTER_EN
    dir_d  = dir_q;
`endif
    if (!run) begin
      cnt_d = '0;
`ifdef PWM_CENTER_EN
      dir_d = 1'b0;
    end else if (tick && cmode_q) begin
      // Up to the top, then down; the commit happens on reaching 0.
      if (dir_q) begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d  = '0;
          dir_d  = 1'b0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (at_top) begin
        if (period_act_q == '0) begin
          wrap_d = 1'b1;
        end else begin
          dir_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end else if (tick) begin
`ifdef PWM_CENTER_EN
      dir_d = 1'b0;
`endif
      if (at_top) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = en_q[c]
               ? ((cnt_q < duty_act_q[c]) ^ pol_q[c])
               : pol_q[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_sh_q  <= '0;
      period_act_q <= '0;
      cnt_q        <= '0;
      div_int_q    <= 16'd1;
      div_frac_q   <= '0;
      en_q         <= '0;
      pol_q        <= '0;
      pwm_q        <= '0;
      wrap_q       <= 1'b0;
      wrap_cnt_q   <= '0;
      dout_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_sh_q[c]  <= '0;
        duty_act_q[c] <= '0;
      end
`ifdef PWM_CENTER_EN
      cmode_q <= 1'b0;
      dir_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      pwm_q  <= pwm_d;
`ifdef PWM_CENTER_EN
      dir_q  <= dir_d;
`endif
      if (wrap_d) begin
        wrap_cnt_q <= wrap_cnt_q + 16'd1;
      end
      // Active registers always take the pre-edge shadow contents.
      if (wrap_d || en_rise) begin
        period_act_q <= period_sh_q;
        for (int c = 0; c < NUM_CH; c++) begin
          duty_act_q[c] <= duty_sh_q[c];
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (action == A_DUTY && 32'(index) == c) begin
          duty_sh_q[c] <= din[CNT_W-1:0];
        end
      end
      case (action)
        A_PERIOD: period_sh_q <= din[CNT_W-1:0];
        A_DIV: begin
          div_int_q  <= din[23:8];
          div_frac_q <= din[7:0];
        end
        A_EN:     en_q   <= din[NUM_CH-1:0];
        A_POL:    pol_q  <= din[NUM_CH-1:0];
        A_READ:   dout_q <= {wrap_cnt_q, cnt16};
`ifdef PWM_CENTER_EN
        A_CMODE:  cmode_q <= din[0];
`endif
        default: ;
      endcase
    end
  end

  assign dout    = dout_q;
  assign pwm_out = pwm_q;
  assign wrap    = wrap_q;
  assign running = run;

endmodule
